down_counter: RTL and testbench



---
 rtl/down_counter.sv | 102 ++++++++++
 tb/tb_down_counter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/down_counter.sv
// Down-counter: loads a clamped start index and emits it down to 0 over valid/ready, then pulses done_o.
// Optional DOWN_COUNTER_ABORT_EN adds abort_i to cancel a count in flight.
module down_counter #(
   parameter int unsigned WORD_SIZE = 16,
   parameter int unsigned INPUT_MAX = 10
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic                 start_i,
   input  logic [WORD_SIZE-1:0] start_value_i,
   input  logic                 ready_i,
`ifdef DOWN_COUNTER_ABORT_EN
   input  logic                 abort_i,
`endif
   output logic                 valid_o,
   output logic [WORD_SIZE-1:0] data_o,
   output logic                 last_o,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam logic [WORD_SIZE-1:0] MAX_W = WORD_SIZE'(INPUT_MAX);

   typedef enum logic [1:0] {
      eIDLE,
      eCOUNTING,
      eDONE
   } state_t;

   state_t               state;
   logic                 abort_c;
   logic [WORD_SIZE-1:0] load_val_c;

`ifdef DOWN_COUNTER_ABORT_EN
   assign abort_c = abort_i;
`else
   assign abort_c = 1'b0;
`endif

   // Start index clamped to the largest index this layer ever emits
   assign load_val_c = (start_value_i > MAX_W) ? MAX_W : start_value_i;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state   <= eIDLE;
         valid_o <= 1'b0;
         data_o  <= '0;
         last_o  <= 1'b0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         done_o <= 1'b0;
         unique case (state)
            eIDLE, eDONE: begin
               if (start_i) begin
                  state   <= eCOUNTING;
                  valid_o <= 1'b1;
                  busy_o  <= 1'b1;
                  data_o  <= load_val_c;
                  last_o  <= (load_val_c == '0);
               end else begin
                  state   <= eIDLE;
                  valid_o <= 1'b0;
                  busy_o  <= 1'b0;
                  data_o  <= '0;
                  last_o  <= 1'b0;
               end
            end
            eCOUNTING: begin
               if (abort_c) begin
                  state   <= eIDLE;
                  valid_o <= 1'b0;
                  busy_o  <= 1'b0;
                  data_o  <= '0;
                  last_o  <= 1'b0;
               end else if (ready_i) begin
                  if (data_o != '0) begin
                     data_o <= data_o - WORD_SIZE'(1);
                     last_o <= (data_o == WORD_SIZE'(1));
                  end else begin
                     // Final beat accepted: 0 is terminal, never wraps
                     state   <= eDONE;
                     valid_o <= 1'b0;
                     busy_o  <= 1'b0;
                     last_o  <= 1'b0;
                     data_o  <= '0;
                     done_o  <= 1'b1;
                  end
               end
            end
            default: begin
               state   <= eIDLE;
               valid_o <= 1'b0;
               busy_o  <= 1'b0;
               data_o  <= '0;
               last_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: vector table plus hand sequences for reset and abort.
module tb_down_counter;

   localparam int unsigned W = 16;

   typedef struct packed {
      logic         valid;
      logic [W-1:0] data;
      logic         last;
      logic         busy;
      logic         done;
   } outs_t;

   typedef struct {
      logic         start;
      logic [W-1:0] sv;
      logic         rdy;
      outs_t        exp;
   } vec_t;

   logic         clk_i = 1'b0;
   logic         reset_n_i;
   logic         start_i;
   logic [W-1:0] start_value_i;
   logic         ready_i;
   logic         abort_i;
   logic         valid_o;
   logic [W-1:0] data_o;
   logic         last_o;
   logic         busy_o;
   logic         done_o;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t vecs[$];

   down_counter #(.WORD_SIZE(W), .INPUT_MAX(10)) dut (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .start_i       (start_i),
      .start_value_i (start_value_i),
      .ready_i       (ready_i),
`ifdef DOWN_COUNTER_ABORT_EN
      .abort_i       (abort_i),
`endif
      .valid_o       (valid_o),
      .data_o        (data_o),
      .last_o        (last_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic outs_t mk(logic v, int d, logic l, logic b, logic dn);
      outs_t r;
      r.valid = v;
      r.data  = W'(d);
      r.last  = l;
      r.busy  = b;
      r.done  = dn;
      return r;
   endfunction

   function automatic void add(logic st, int sv, logic rdy, outs_t e);
      vec_t v;
      v.start = st;
      v.sv    = W'(sv);
      v.rdy   = rdy;
      v.exp   = e;
      vecs.push_back(v);
   endfunction

   task automatic check(string name, outs_t exp);
      outs_t act;
      act = {valid_o, data_o, last_o, busy_o, done_o};
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got v=%0b d=%0d l=%0b b=%0b dn=%0b, want v=%0b d=%0d l=%0b b=%0b dn=%0b",
                  name, act.valid, act.data, act.last, act.busy, act.done,
                  exp.valid, exp.data, exp.last, exp.busy, exp.done);
      end
   endtask

   // Drive inputs on the falling edge, sample 1 time unit after the next rising edge
   task automatic step(logic st, int sv, logic rdy, logic ab);
      @(negedge clk_i);
      start_i       = st;
      start_value_i = W'(sv);
      ready_i       = rdy;
      abort_i       = ab;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      outs_t zero;
      zero = mk(0, 0, 0, 0, 0);

      // 3 -> 0 with ready held high
      add(1, 3, 1, mk(1, 3, 0, 1, 0));
      add(0, 0, 1, mk(1, 2, 0, 1, 0));
      add(0, 0, 1, mk(1, 1, 0, 1, 0));
      add(0, 0, 1, mk(1, 0, 1, 1, 0));
      add(0, 0, 1, mk(0, 0, 0, 0, 1));
      add(0, 0, 1, zero);
      // 2 -> 0 with stalls on the 2nd and 3rd valid cycles
      add(1, 2, 1, mk(1, 2, 0, 1, 0));
      add(0, 0, 1, mk(1, 1, 0, 1, 0));
      add(0, 0, 0, mk(1, 1, 0, 1, 0));
      add(0, 0, 0, mk(1, 1, 0, 1, 0));
      add(0, 0, 1, mk(1, 0, 1, 1, 0));
      add(0, 0, 1, mk(0, 0, 0, 0, 1));
      add(0, 0, 1, zero);
      // 20 clamps to 10: 11 beats
      add(1, 20, 1, mk(1, 10, 0, 1, 0));
      for (int i = 9; i >= 0; i--) add(0, 0, 1, mk(1, i, (i == 0), 1, 0));
      add(0, 0, 1, mk(0, 0, 0, 0, 1));
      add(0, 0, 0, zero);
      // start value 0: single beat
      add(1, 0, 0, mk(1, 0, 1, 1, 0));
      add(0, 0, 0, mk(1, 0, 1, 1, 0));
      add(0, 0, 1, mk(0, 0, 0, 0, 1));
      add(0, 0, 0, zero);
      // start mid-run ignored; start in done cycle reloads with no gap
      add(1, 3, 1, mk(1, 3, 0, 1, 0));
      add(1, 7, 1, mk(1, 2, 0, 1, 0));
      add(1, 7, 0, mk(1, 2, 0, 1, 0));
      add(0, 0, 1, mk(1, 1, 0, 1, 0));
      add(0, 0, 1, mk(1, 0, 1, 1, 0));
      add(0, 0, 1, mk(0, 0, 0, 0, 1));
      add(1, 1, 1, mk(1, 1, 0, 1, 0));
      add(0, 0, 1, mk(1, 0, 1, 1, 0));
      add(0, 0, 1, mk(0, 0, 0, 0, 1));
      add(0, 0, 1, zero);

      reset_n_i     = 1'b0;
      start_i       = 1'b0;
      start_value_i = '0;
      ready_i       = 1'b0;
      abort_i       = 1'b0;
      #1;
      check("reset_async", zero);
      repeat (2) @(posedge clk_i);
      #1;
      check("reset_held", zero);
      @(negedge clk_i);
      reset_n_i = 1'b1;

      foreach (vecs[i]) begin
         step(vecs[i].start, int'(vecs[i].sv), vecs[i].rdy, 1'b0);
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Asynchronous reset mid-count at data 5
      step(1, 9, 1, 0);
      for (int i = 8; i >= 5; i--) step(0, 0, 1, 0);
      check("pre_reset_at5", mk(1, 5, 0, 1, 0));
      #2;
      reset_n_i = 1'b0;
      #1;
      check("mid_reset_immediate", zero);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      step(0, 0, 1, 0);
      check("post_reset_no_done", zero);
      step(1, 1, 1, 0);
      check("post_reset_start", mk(1, 1, 0, 1, 0));
      step(0, 0, 1, 0);
      check("post_reset_last", mk(1, 0, 1, 1, 0));
      step(0, 0, 1, 0);
      check("post_reset_done", mk(0, 0, 0, 0, 1));
      step(0, 0, 1, 0);
      check("post_reset_idle", zero);

`ifdef DOWN_COUNTER_ABORT_EN
      // Abort at data 4 wins over a simultaneous handshake
      step(1, 6, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      check("pre_abort_at4", mk(1, 4, 0, 1, 0));
      step(0, 0, 1, 1);
      check("abort_clears", zero);
      step(0, 0, 1, 0);
      check("abort_no_done", zero);
      step(1, 2, 1, 1);
      check("abort_idle_noeffect", mk(1, 2, 0, 1, 0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
